control: RTL and testbench



---
 rtl/control_pkg.sv | 31 +++
 rtl/control_sync_bit.sv | 33 +++
 rtl/control.sv | 95 +++++++++
 tb/tb_control.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and constants for the oven run/stop controller.
// Reason codes are only consumed when CONTROL_REASON_EN is defined.
package control_pkg;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_t;

  localparam logic [1:0] REASON_NONE  = 2'd0;
  localparam logic [1:0] REASON_STOP  = 2'd1;
  localparam logic [1:0] REASON_TIMER = 2'd2;
  localparam logic [1:0] REASON_DOOR  = 2'd3;

  // Idle levels of the synchronized input groups: {startn, stopn, clearn} and {door_closed, timer_done}
  localparam logic [2:0] BUTTONS_IDLE = 3'b111;
  localparam logic [1:0] STATUS_IDLE  = 2'b00;

  // Highest-priority active cause wins when several block together
  function automatic logic [1:0] reasonCode(input logic stopOrClear,
                                            input logic timerDone,
                                            input logic doorOpen);
    logic [1:0] code;
    code = REASON_NONE;
    if (stopOrClear)    code = REASON_STOP;
    else if (timerDone) code = REASON_TIMER;
    else if (doorOpen)  code = REASON_DOOR;
    return code;
  endfunction

endpackage

// File: rtl/control_sync_bit.sv
// Multi-flop synchronizer for a group of asynchronous inputs with a configurable
// depth (0 = pass-through) and a per-bit synchronous reset value.
module sync_bit #(
  parameter int               DEPTH     = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_sync
      logic [WIDTH-1:0] r_stages [DEPTH];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int i = 0; i < DEPTH; i++) r_stages[i] <= RESET_VAL;
        end else begin
          r_stages[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_stages[i] <= r_stages[i-1];
        end
      end

      assign o_q = r_stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/control.sv
// Microwave run/stop controller driving the magnetron enable Q.
// Optional turn-off cause output 'reason' is built when CONTROL_REASON_EN is defined.
module control
  import control_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       timer_done,
  output logic       Q
`ifdef CONTROL_REASON_EN
  ,
  output logic [1:0] reason
`endif
);

  logic [2:0] w_buttons;
  logic [1:0] w_status;
  logic       w_startn;
  logic       w_stopn;
  logic       w_clearn;
  logic       w_doorClosed;
  logic       w_timerDone;
  logic       w_block;
  logic       w_go;
  state_t     r_state;
  state_t     w_stateNext;

  sync_bit #(
    .DEPTH    (SYNC_STAGES),
    .WIDTH    (3),
    .RESET_VAL(BUTTONS_IDLE)
  ) u_syncButtons (
    .clk (clk),
    .rstn(rstn),
    .i_d ({startn, stopn, clearn}),
    .o_q (w_buttons)
  );

  sync_bit #(
    .DEPTH    (SYNC_STAGES),
    .WIDTH    (2),
    .RESET_VAL(STATUS_IDLE)
  ) u_syncStatus (
    .clk (clk),
    .rstn(rstn),
    .i_d ({door_closed, timer_done}),
    .o_q (w_status)
  );

  assign {w_startn, w_stopn, w_clearn} = w_buttons;
  assign {w_doorClosed, w_timerDone}   = w_status;

  // Any blocker vetoes start, so a held start fires only once the last blocker clears
  assign w_block = !w_stopn || !w_clearn || w_timerDone || !w_doorClosed;
  assign w_go    = !w_startn && w_doorClosed;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= OFF;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      OFF:     if (w_go && !w_block) w_stateNext = ON;
      ON:      if (w_block)          w_stateNext = OFF;
      default: w_stateNext = OFF;
    endcase
  end

  assign Q = (r_state == ON);

`ifdef CONTROL_REASON_EN
  logic [1:0] r_reason;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_reason <= REASON_NONE;
    end else if (r_state == OFF && w_stateNext == ON) begin
      r_reason <= REASON_NONE;
    end else if (r_state == ON && w_stateNext == OFF) begin
      r_reason <= reasonCode(!w_stopn || !w_clearn, w_timerDone, !w_doorClosed);
    end
  end

  assign reason = r_reason;
`endif

endmodule

// File: tb/tb_control.sv
// Table-driven self-checking bench for control with SYNC_STAGES=2 (3-edge latency).
module tb_control;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       startn = 1'b1;
  logic       stopn = 1'b1;
  logic       clearn = 1'b1;
  logic       door_closed = 1'b0;
  logic       timer_done = 1'b0;
  logic       Q;
`ifdef CONTROL_REASON_EN
  logic [1:0] reason;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    string    name;
    logic     rstn;
    logic     startn;
    logic     stopn;
    logic     clearn;
    logic     door;
    logic     timer;
    int       cycles;
    logic     expQ;
    logic [1:0] expReason;
  } step_t;

  step_t steps[$];

  control #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .startn     (startn),
    .stopn      (stopn),
    .clearn     (clearn),
    .door_closed(door_closed),
    .timer_done (timer_done),
    .Q          (Q)
`ifdef CONTROL_REASON_EN
    ,
    .reason     (reason)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic sp,
                               input logic cl, input logic dr, input logic tm);
    rstn        = r;
    startn      = st;
    stopn       = sp;
    clearn      = cl;
    door_closed = dr;
    timer_done  = tm;
  endtask

  task automatic checkOutput(input string name, input logic expQ, input logic [1:0] expReason);
    checks++;
    if (Q !== expQ) begin
      failures++;
      $display("[TB] FAIL %s: Q=%b expected %b at %0t", name, Q, expQ, $time);
    end
`ifdef CONTROL_REASON_EN
    checks++;
    if (reason !== expReason) begin
      failures++;
      $display("[TB] FAIL %s: reason=%0d expected %0d at %0t", name, reason, expReason, $time);
    end
`else
    if (expReason > 2'd3) $display("[TB] unreachable");
`endif
  endtask

  task automatic addStep(input string name, input logic r, input logic st, input logic sp,
                         input logic cl, input logic dr, input logic tm, input int cyc,
                         input logic eq, input logic [1:0] er);
    step_t s;
    s.name = name; s.rstn = r; s.startn = st; s.stopn = sp; s.clearn = cl;
    s.door = dr; s.timer = tm; s.cycles = cyc; s.expQ = eq; s.expReason = er;
    steps.push_back(s);
  endtask

  initial begin
    //       name            rstn st sp cl dr tm cyc Q  reason
    addStep("reset",         0,  1, 1, 1, 0, 0, 2,  0, 0);
    addStep("idle",          1,  1, 1, 1, 0, 0, 3,  0, 0);
    addStep("startNoDoor",   1,  0, 1, 1, 0, 0, 5,  0, 0);
    addStep("doorLat2",      1,  0, 1, 1, 1, 0, 2,  0, 0);
    addStep("doorLat3",      1,  0, 1, 1, 1, 0, 1,  1, 0);
    addStep("startRelease",  1,  1, 1, 1, 1, 0, 5,  1, 0);
    addStep("doorOpen2",     1,  1, 1, 1, 0, 0, 2,  1, 0);
    addStep("doorOpen3",     1,  1, 1, 1, 0, 0, 1,  0, 3);
    addStep("doorReclose",   1,  1, 1, 1, 1, 0, 5,  0, 3);
    addStep("restartA",      1,  0, 1, 1, 1, 0, 3,  1, 0);
    addStep("holdA",         1,  1, 1, 1, 1, 0, 2,  1, 0);
    addStep("stopLow",       1,  1, 0, 1, 1, 0, 2,  1, 0);
    addStep("stopOff",       1,  1, 1, 1, 1, 0, 1,  0, 1);
    addStep("settleA",       1,  1, 1, 1, 1, 0, 3,  0, 1);
    addStep("restartB",      1,  0, 1, 1, 1, 0, 3,  1, 0);
    addStep("holdB",         1,  1, 1, 1, 1, 0, 2,  1, 0);
    addStep("clearLow",      1,  1, 1, 0, 1, 0, 2,  1, 0);
    addStep("clearOff",      1,  1, 1, 1, 1, 0, 1,  0, 1);
    addStep("settleB",       1,  1, 1, 1, 1, 0, 3,  0, 1);
    addStep("restartC",      1,  0, 1, 1, 1, 0, 3,  1, 0);
    addStep("holdC",         1,  1, 1, 1, 1, 0, 2,  1, 0);
    addStep("timerHigh",     1,  1, 1, 1, 1, 1, 2,  1, 0);
    addStep("timerOff",      1,  1, 1, 1, 1, 0, 1,  0, 2);
    addStep("settleC",       1,  1, 1, 1, 1, 0, 3,  0, 2);
    addStep("stopHold",      1,  1, 0, 1, 1, 0, 3,  0, 2);
    addStep("stopStart",     1,  0, 0, 1, 1, 0, 3,  0, 2);
    addStep("stopStartRel",  1,  1, 0, 1, 1, 0, 3,  0, 2);
    addStep("stopRelease",   1,  1, 1, 1, 1, 0, 4,  0, 2);
    addStep("clearHold",     1,  1, 1, 0, 1, 0, 3,  0, 2);
    addStep("clearStart",    1,  0, 1, 0, 1, 0, 3,  0, 2);
    addStep("clearStartRel", 1,  1, 1, 0, 1, 0, 3,  0, 2);
    addStep("clearRelease",  1,  1, 1, 1, 1, 0, 4,  0, 2);
    addStep("timerHold",     1,  1, 1, 1, 1, 1, 3,  0, 2);
    addStep("timerStart",    1,  0, 1, 1, 1, 1, 3,  0, 2);
    addStep("timerStartRel", 1,  1, 1, 1, 1, 1, 3,  0, 2);
    addStep("timerRelease",  1,  1, 1, 1, 1, 0, 4,  0, 2);
    addStep("timerHeldStart",1,  0, 1, 1, 1, 1, 4,  0, 2);
    addStep("timerDrop2",    1,  0, 1, 1, 1, 0, 2,  0, 2);
    addStep("timerDrop3",    1,  0, 1, 1, 1, 0, 1,  1, 0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    foreach (steps[i]) begin
      applyStimulus(steps[i].rstn, steps[i].startn, steps[i].stopn,
                    steps[i].clearn, steps[i].door, steps[i].timer);
      tick(steps[i].cycles);
      checkOutput(steps[i].name, steps[i].expQ, steps[i].expReason);
    end

    // Reset while running with start held: off on the reset edge, refill before turn-on
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("midReset", 1'b0, 2'd0);
    tick(2);
    checkOutput("resetHeld", 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 2; e++) begin
      tick(1);
      checkOutput($sformatf("refill%0d", e), 1'b0, 2'd0);
    end
    tick(1);
    checkOutput("refillOn", 1'b1, 2'd0);

    // Door opens together with stop: stop/clear cause takes priority
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(3);
    checkOutput("priorityStop", 1'b0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
